imem_fetch: RTL
===============

# imem_fetch

Parametrised, clocked instruction memory with a valid/ready fetch port, a configurable number of wait states, and a program-load write port. It replaces the combinational instruction ROM in the MIPS datapath so the fetch stage can model realistic memory latency and back-pressure. It also flags misaligned and out-of-range fetches instead of returning arbitrary data.

## Interface
- `DEPTH`, 256: memory size in 32-bit words; must be a power of two, 2..65536.
- `WAIT_STATES`, 0: extra cycles between request acceptance and response; legal range 0..15.
- `AW`, `$clog2(DEPTH)`: derived word-index width; not overridden.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous reset, active-low.
- `req_valid`  in  1  fetch request present.
- `req_ready`  out  1  block can accept a request.
- `req_addr`  in  32  byte address of the instruction.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  32  instruction word; 0 when `rsp_err` is set.
- `rsp_err`  out  1  fetch was misaligned or out of range.
- `prog_we`  in  1  program-load write enable.
- `prog_addr`  in  AW  word index for the program load.
- `prog_wdata`  in  32  word to write.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Storage is a DEPTH x 32 array. It is not reset, so contents survive `rst_n`.
- FSM states and transitions:
  - IDLE → WAIT on request handshake when `WAIT_STATES` > 0.
  - IDLE → RESP on request handshake when `WAIT_STATES` = 0.
  - WAIT → RESP when the wait counter reaches `WAIT_STATES`-1.
  - RESP → IDLE on `rsp_valid && rsp_ready`.
- `req_ready` = (state == IDLE). Request handshake = `req_valid && req_ready`.
- On handshake, `req_addr` is latched and the wait counter is cleared. Later changes to `req_addr` have no effect.
- Error check on the latched address:
  - misaligned: `addr[1:0]` != 0;
  - out of range: `addr[31:2]` >= DEPTH.
  - Either condition sets `rsp_err`=1 and `rsp_data`=0.
- Otherwise `rsp_data` = mem[`addr[AW+1:2]`].
- Read timing: the array is read on the clock edge that enters RESP, and the result is registered.
  - `rsp_data` and `rsp_err` stay stable throughout RESP regardless of `prog_we`.
- Program writes:
  - `prog_we` writes `prog_wdata` to mem[`prog_addr`] on the rising edge, in every state.
  - If a write and a read of the same word fall on the same edge, the read returns the old word (read-before-write). The write still completes.
- Only one transaction is in flight at a time. A new request is accepted no earlier than the cycle after the response handshake.

## Timing
- Reset (asynchronous, immediate on `rst_n` low):
  - state = IDLE, counter = 0;
  - `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `busy`=0;
  - `req_ready` is 0 while `rst_n` is low and 1 from the first edge after release.
- Latency: a handshake on edge N gives `rsp_valid`=1 after edge N+1+`WAIT_STATES`.
- `rsp_valid` holds until the edge where `rsp_ready`=1. With `rsp_ready` tied high, the response lasts exactly one cycle.
- Throughput: at best one fetch per 2+`WAIT_STATES` cycles.
- Reset in WAIT or RESP aborts the transaction; no response is issued for it.
- The counter is 4 bits and never wraps beyond `WAIT_STATES`-1. When `WAIT_STATES`=0 it is unused.
- `req_valid` low while in IDLE leaves the FSM in IDLE. `rsp_ready` asserted outside RESP is ignored.

## Test plan
- **Load and basic fetch** (`WAIT_STATES`=0):
  - Load words 0..9 via `prog_we`, with word 9 = 0x08000009.
  - Request 0x24 → after 1 edge, `rsp_valid`=1, `rsp_data`=0x08000009, `rsp_err`=0.
- **Back-pressure:**
  - Hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid`/`rsp_data` stay stable and `req_ready`=0.
  - Assert `rsp_ready` → IDLE and `req_ready`=1 on the next cycle.
- **Errors:**
  - Request 0x06 → `rsp_err`=1, `rsp_data`=0.
  - Request 0x400 with `DEPTH`=256 → `rsp_err`=1, `rsp_data`=0.
  - Both responses arrive with normal latency.
- **Wait states** (`WAIT_STATES`=3):
  - Request 0x08 → `rsp_valid` rises exactly 4 edges after the handshake and `busy`=1 throughout.
- **Write/read collision:**
  - Word 2 = 0x01095020; write 0xDEADBEEF to word 2 on the same edge RESP is entered → `rsp_data`=0x01095020.
  - A following fetch of word 2 returns 0xDEADBEEF.
- **Reset mid-transaction** (`WAIT_STATES`=3):
  - Pull `rst_n` low in WAIT → outputs clear immediately and no response appears.
  - After release, earlier loaded words still fetch correctly.

Source files
------------

// File: rtl/imem_fetch.sv
// Clocked instruction memory with a valid/ready fetch port, programmable wait
// states, a program-load write port and misaligned/out-of-range fetch flagging.
module imem_fetch #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_addr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_data,
    output logic          rsp_err,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_wdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   addr_q;
    logic          ready_q, valid_q, busy_q, err_q;
    logic [31:0]   data_q;
    logic [31:0]   mem [DEPTH];

    logic          hs_s;
    logic          enter_resp_s;
    logic [31:0]   rd_addr_s;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH));
    endfunction

    assign hs_s         = req_valid && ready_q;
    assign enter_resp_s = (state_d == S_RESP) && (state_q != S_RESP);
    // With zero wait states RESP is entered on the handshake edge itself,
    // before the address has been latched.
    assign rd_addr_s    = (state_q == S_IDLE) ? req_addr : addr_q;

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (hs_s) begin
                    cnt_d = 4'd0;
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'(WAIT_STATES - 1)) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // FSM state, address latch and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == S_IDLE);
            valid_q <= (state_d == S_RESP);
            busy_q  <= (state_d != S_IDLE);
            if (hs_s) begin
                addr_q <= req_addr;
            end
            // Nonblocking read here sees the pre-write word on a colliding edge.
            if (enter_resp_s) begin
                if (addr_bad(rd_addr_s)) begin
                    data_q <= 32'd0;
                    err_q  <= 1'b1;
                end else begin
                    data_q <= mem[rd_addr_s[AW+1:2]];
                    err_q  <= 1'b0;
                end
            end
        end
    end

    // Program-load port; the array is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = valid_q;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;
    assign busy      = busy_q;

endmodule
